// File: rtl/timer16_pkg.sv
// Shared register map, bit positions and prescale encodings for the timer16
// interval timer and its prescaler.
package timer16_pkg;

  localparam logic [2:0] T16_CTRL = 3'd0;
  localparam logic [2:0] T16_STAT = 3'd1;
  localparam logic [2:0] T16_RLO  = 3'd2;
  localparam logic [2:0] T16_RHI  = 3'd3;
  localparam logic [2:0] T16_CLO  = 3'd4;
  localparam logic [2:0] T16_CHI  = 3'd5;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_OS    = 1;
  localparam int CTRL_IE    = 2;
  localparam int CTRL_PS_LO = 4;

  localparam int STAT_TF  = 0;
  localparam int STAT_RUN = 7;

  typedef enum logic [1:0] {
    PS_DIV1    = 2'd0,
    PS_DIV16   = 2'd1,
    PS_DIV256  = 2'd2,
    PS_DIV4096 = 2'd3
  } ps_e;

endpackage

// File: rtl/timer16_prescale.sv
// Free-running prescaler for timer16: counts while enabled and emits a
// one-cycle tick whenever the selected number of low bits are all ones.
module timer16_prescale
  import timer16_pkg::*;
#(
  parameter int PRE_W = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] ps,
  output logic       tick
);

  logic [PRE_W-1:0] cnt;
  logic [PRE_W-1:0] mask;

  always_comb begin
    mask = '0;
    case (ps_e'(ps))
      PS_DIV1:    mask = '0;
      PS_DIV16:   mask = PRE_W'(12'h00F);
      PS_DIV256:  mask = PRE_W'(12'h0FF);
      PS_DIV4096: mask = PRE_W'(12'hFFF);
      default:    mask = '0;
    endcase
  end

  // With an all-zero mask the compare is always true, so /1 ticks every enabled cycle.
  assign tick = en & ((cnt & mask) == mask);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/timer16.sv
// Memory-mapped 16-bit interval timer on the 6502 bus: reload, prescale,
// one-shot/continuous modes, level IRQ and registered read data.
module timer16
  import timer16_pkg::*;
#(
  parameter int PRE_W = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq
);

  logic        en;
  logic        os;
  logic        ie;
  logic [1:0]  ps;
  logic        tf;
  logic [7:0]  rld_lo;
  logic [7:0]  rld_hi;
  logic [7:0]  snap;
  logic [15:0] count;
  logic [7:0]  rdata;

  logic wr;
  logic wr_ctrl;
  logic wr_stat;
  logic wr_rlo;
  logic wr_rhi;
  logic rd_clo;
  logic en_rise;
  logic pre_clr;
  logic tick;
  logic uf;

  assign wr      = cs & we;
  assign wr_ctrl = wr & (addr == T16_CTRL);
  assign wr_stat = wr & (addr == T16_STAT);
  assign wr_rlo  = wr & (addr == T16_RLO);
  assign wr_rhi  = wr & (addr == T16_RHI);
  assign rd_clo  = cs & ~we & (addr == T16_CLO);

  assign en_rise = wr_ctrl & din[CTRL_EN] & ~en;
  assign pre_clr = wr_rhi | en_rise;

  timer16_prescale #(
    .PRE_W(PRE_W)
  ) u_prescale (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (pre_clr),
    .ps   (ps),
    .tick (tick)
  );

  // A reload via RHI on the same cycle as a tick suppresses the underflow.
  assign uf = tick & (count == 16'h0000) & ~wr_rhi;

  always_comb begin
    rdata = 8'h00;
    case (addr)
      T16_CTRL: rdata = {2'b00, ps, 1'b0, ie, os, en};
      T16_STAT: rdata = {en, 6'b000000, tf};
      T16_RLO:  rdata = rld_lo;
      T16_RHI:  rdata = rld_hi;
      T16_CLO:  rdata = count[7:0];
      T16_CHI:  rdata = snap;
      default:  rdata = 8'h00;
    endcase
  end

  // Later assignments in this block take priority: underflow beats W1C and
  // one-shot auto-clear beats a written EN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en     <= 1'b0;
      os     <= 1'b0;
      ie     <= 1'b0;
      ps     <= 2'b00;
      tf     <= 1'b0;
      rld_lo <= 8'h00;
      rld_hi <= 8'h00;
      snap   <= 8'h00;
      count  <= 16'h0000;
      dout   <= 8'h00;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en <= din[CTRL_EN];
        os <= din[CTRL_OS];
        ie <= din[CTRL_IE];
        ps <= din[CTRL_PS_LO +: 2];
      end
      if (uf && os) en <= 1'b0;

      if (wr_stat && din[STAT_TF]) tf <= 1'b0;
      if (uf) tf <= 1'b1;

      if (wr_rlo) rld_lo <= din;
      if (wr_rhi) rld_hi <= din;

      if (wr_rhi) begin
        count <= {din, rld_lo};
      end else if (uf) begin
        count <= {rld_hi, rld_lo};
      end else if (tick) begin
        count <= count - 16'h0001;
      end

      if (rd_clo) snap <= count[15:8];

      dout <= rdata;
      irq  <= tf & ie;
    end
  end

endmodule

// File: tb/tb_timer16.sv
// Self-checking bench for timer16: cycle-by-cycle vector tables plus
// hand-written sequences for the atomic read and the mid-count reset.
module tb_timer16;

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_STAT = 3'd1;
  localparam logic [2:0] A_RLO  = 3'd2;
  localparam logic [2:0] A_RHI  = 3'd3;
  localparam logic [2:0] A_CLO  = 3'd4;
  localparam logic [2:0] A_CHI  = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       cs;
    logic       we;
    logic [2:0] addr;
    logic [7:0] din;
    logic       chk;
    logic [7:0] exp_dout;
    logic       exp_irq;
  } vec_t;

  vec_t vq[$];

  timer16 #(
    .PRE_W(12)
  ) dut (
    .clk  (clk),
    .rst  (rst_n),
    .cs   (cs),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  function automatic void add_rd(input logic [2:0] a, input logic [7:0] e, input logic ei);
    vec_t v;
    v.cs = 1'b1; v.we = 1'b0; v.addr = a; v.din = 8'h00;
    v.chk = 1'b1; v.exp_dout = e; v.exp_irq = ei;
    vq.push_back(v);
  endfunction

  function automatic void add_wr(input logic [2:0] a, input logic [7:0] d, input logic ei);
    vec_t v;
    v.cs = 1'b1; v.we = 1'b1; v.addr = a; v.din = d;
    v.chk = 1'b0; v.exp_dout = 8'h00; v.exp_irq = ei;
    vq.push_back(v);
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h, expected %04h", name, act, exp);
    end
  endtask

  task automatic step(input logic c, input logic w, input logic [2:0] a, input logic [7:0] d);
    cs = c; we = w; addr = a; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].cs, vq[i].we, vq[i].addr, vq[i].din);
      n_cmp++;
      if (irq !== vq[i].exp_irq) begin
        n_fail++;
        $display("FAIL %s[%0d] irq: got %b, expected %b", name, i, irq, vq[i].exp_irq);
      end
      if (vq[i].chk) begin
        n_cmp++;
        if (dout !== vq[i].exp_dout) begin
          n_fail++;
          $display("FAIL %s[%0d] addr%0d dout: got %02h, expected %02h",
                   name, i, vq[i].addr, dout, vq[i].exp_dout);
        end
      end
    end
    vq.delete();
    step(1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    logic [7:0] lo;
    logic [7:0] hi;

    rst_n = 1'b0; cs = 1'b0; we = 1'b0; addr = 3'd0; din = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state of every address
    for (int a = 0; a < 8; a++) add_rd(3'(a), 8'h00, 1'b0);
    run_table("reset");

    // Continuous /1, reload 3, IE on
    add_wr(A_RLO, 8'h03, 0); add_wr(A_RHI, 8'h00, 0); add_wr(A_CTRL, 8'h05, 0);
    add_rd(A_CLO, 8'h03, 0); add_rd(A_CLO, 8'h02, 0); add_rd(A_CLO, 8'h01, 0);
    add_rd(A_STAT, 8'h80, 0); add_rd(A_STAT, 8'h81, 1); add_wr(A_STAT, 8'h01, 1);
    add_rd(A_STAT, 8'h80, 0); add_rd(A_CLO, 8'h00, 0); add_rd(A_STAT, 8'h81, 1);
    add_wr(A_STAT, 8'h01, 1); add_rd(A_CTRL, 8'h05, 0); add_rd(A_STAT, 8'h80, 0);
    add_rd(A_STAT, 8'h81, 1); add_wr(A_CTRL, 8'h00, 1); add_rd(A_STAT, 8'h01, 0);
    add_wr(A_STAT, 8'h01, 0); add_rd(A_STAT, 8'h00, 0);
    run_table("cont");

    // One-shot /16, reload 1: single underflow 32 edges after the CTRL write
    add_wr(A_RLO, 8'h01, 0); add_wr(A_RHI, 8'h00, 0); add_wr(A_CTRL, 8'h13, 0);
    for (int k = 1; k <= 32; k++) add_rd(A_STAT, 8'h80, 0);
    add_rd(A_STAT, 8'h01, 0); add_rd(A_CLO, 8'h01, 0); add_rd(A_CHI, 8'h00, 0);
    add_rd(A_CTRL, 8'h12, 0); add_rd(A_STAT, 8'h01, 0); add_rd(A_CLO, 8'h01, 0);
    add_wr(A_STAT, 8'h01, 0);
    run_table("oneshot");

    // Collisions: RHI load vs underflow, W1C vs underflow, CTRL write vs auto-clear
    add_wr(A_RLO, 8'h02, 0); add_wr(A_RHI, 8'h00, 0); add_wr(A_CTRL, 8'h01, 0);
    add_rd(A_CLO, 8'h02, 0); add_rd(A_CLO, 8'h01, 0); add_wr(A_RHI, 8'h00, 0);
    add_rd(A_STAT, 8'h80, 0); add_rd(A_CLO, 8'h01, 0); add_rd(A_STAT, 8'h80, 0);
    add_rd(A_STAT, 8'h81, 0); add_rd(A_CLO, 8'h01, 0); add_wr(A_STAT, 8'h01, 0);
    add_rd(A_STAT, 8'h81, 0); add_wr(A_CTRL, 8'h03, 0); add_wr(A_CTRL, 8'h03, 0);
    add_rd(A_CTRL, 8'h02, 0); add_rd(A_CLO, 8'h02, 0); add_rd(A_CLO, 8'h02, 0);
    add_wr(A_STAT, 8'h01, 0); add_rd(A_STAT, 8'h00, 0);
    run_table("collide");

    // Atomic CLO/CHI read across the 0x0100 -> 0x00FF rollover
    for (int d = 0; d < 3; d++) begin
      step(1'b1, 1'b1, A_CTRL, 8'h01);
      step(1'b1, 1'b1, A_RLO, 8'h00);
      step(1'b1, 1'b1, A_RHI, 8'h01);
      repeat (d) step(1'b0, 1'b0, A_CTRL, 8'h00);
      step(1'b1, 1'b0, A_CLO, 8'h00);
      lo = dout;
      step(1'b1, 1'b0, A_CHI, 8'h00);
      hi = dout;
      check16($sformatf("atomic_d%0d", d), {hi, lo}, 16'h0100 - 16'(d));
    end
    step(1'b1, 1'b1, A_CTRL, 8'h00);
    step(1'b1, 1'b1, A_STAT, 8'h01);

    // Mid-count reset with TF and irq set
    step(1'b1, 1'b1, A_RLO, 8'h05);
    step(1'b1, 1'b1, A_RHI, 8'h00);
    step(1'b1, 1'b1, A_CTRL, 8'h05);
    repeat (8) step(1'b0, 1'b0, A_STAT, 8'h00);
    check8("pre_reset_irq", {7'd0, irq}, 8'h01);
    check8("pre_reset_dout", dout, 8'h81);
    #2 rst_n = 1'b0;
    #1;
    check8("reset_async_dout", dout, 8'h00);
    check8("reset_async_irq", {7'd0, irq}, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    add_rd(A_CTRL, 8'h00, 0); add_rd(A_STAT, 8'h00, 0); add_rd(A_CLO, 8'h00, 0);
    add_rd(A_CHI, 8'h00, 0); add_rd(A_RLO, 8'h00, 0);
    for (int k = 0; k < 4; k++) add_rd(A_CLO, 8'h00, 0);
    run_table("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
